// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: programs the UART baud/control registers, then round-robin shares its TX register.
// Optional UART_TX_ARB_LOCK_EN lets the last served requester keep the grant for multi-byte messages.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned BAUD_DIV     = 434,
    parameter int unsigned POLL_TIMEOUT = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_lock_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 uart_wr_en_o,
    output logic [31:0]          uart_wr_addr_o,
    output logic [31:0]          uart_wr_data_o,
    output logic [31:0]          uart_rd_addr_o,
    input  logic [31:0]          uart_rd_data_i,
    output logic                 init_done_o,
    output logic                 timeout_o
);

    localparam int unsigned PtrW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] AddrCtrl   = BASE_ADDR + 32'h00;
    localparam logic [31:0] AddrStatus = BASE_ADDR + 32'h04;
    localparam logic [31:0] AddrBaud   = BASE_ADDR + 32'h08;
    localparam logic [31:0] AddrTx     = BASE_ADDR + 32'h0C;
    localparam logic [15:0] PollLast   = 16'(POLL_TIMEOUT - 1);
    localparam logic [PtrW-1:0] RrInit = PtrW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        StInitBaud,
        StInitCtrl,
        StIdle,
        StPoll,
        StWrite,
        StSettle
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] grant_q, grant_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]     poll_cnt_q, poll_cnt_d;
    logic            init_done_q, init_done_d;
    logic            timeout_q, timeout_d;
    logic            lock_ok_q, lock_ok_d;
    logic [PtrW-1:0] win, idx;
    logic            found;
    logic            lock_hit;

    // First valid requester after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        idx   = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = PtrW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // lock_ok_q is cleared by a timeout so a lock never survives an aborted byte.
    assign lock_hit = lock_ok_q & req_lock_i[rr_ptr_q] & req_valid_i[rr_ptr_q];
`else
    logic unused_lock;
    assign lock_hit    = 1'b0;
    assign unused_lock = ^{req_lock_i, lock_ok_q};
`endif

    logic unused_rd;
    assign unused_rd = ^uart_rd_data_i[31:1];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        poll_cnt_d  = poll_cnt_q;
        init_done_d = init_done_q;
        timeout_d   = timeout_q;
        lock_ok_d   = lock_ok_q;
        unique case (state_q)
            StInitBaud: state_d = StInitCtrl;
            StInitCtrl: begin
                state_d     = StIdle;
                init_done_d = 1'b1;
            end
            StIdle: begin
                if (lock_hit) begin
                    grant_d = rr_ptr_q;
                    state_d = StPoll;
                end else if (found) begin
                    grant_d = win;
                    state_d = StPoll;
                end
            end
            StPoll: begin
                if (!uart_rd_data_i[0]) begin
                    state_d    = StWrite;
                    poll_cnt_d = '0;
                end else if (poll_cnt_q == PollLast) begin
                    state_d    = StIdle;
                    timeout_d  = 1'b1;
                    rr_ptr_d   = grant_q;
                    lock_ok_d  = 1'b0;
                    poll_cnt_d = '0;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                end
            end
            StWrite: begin
                state_d   = StSettle;
                rr_ptr_d  = grant_q;
                lock_ok_d = 1'b1;
            end
            StSettle: state_d = StIdle;
            default:  state_d = StInitBaud;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StInitBaud;
            grant_q     <= '0;
            rr_ptr_q    <= RrInit;
            poll_cnt_q  <= '0;
            init_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            lock_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            poll_cnt_q  <= poll_cnt_d;
            init_done_q <= init_done_d;
            timeout_q   <= timeout_d;
            lock_ok_q   <= lock_ok_d;
        end
    end

    // Bus outputs decode the state; forced low while reset is asserted, including in StInitBaud.
    always_comb begin
        uart_wr_en_o   = 1'b0;
        uart_wr_addr_o = '0;
        uart_wr_data_o = '0;
        uart_rd_addr_o = '0;
        req_ready_o    = '0;
        if (rst_n_i) begin
            unique case (state_q)
                StInitBaud: begin
                    uart_wr_en_o   = 1'b1;
                    uart_wr_addr_o = AddrBaud;
                    uart_wr_data_o = 32'(BAUD_DIV);
                end
                StInitCtrl: begin
                    uart_wr_en_o   = 1'b1;
                    uart_wr_addr_o = AddrCtrl;
                    uart_wr_data_o = 32'h1;
                end
                StPoll: uart_rd_addr_o = AddrStatus;
                StWrite: begin
                    uart_wr_en_o         = 1'b1;
                    uart_wr_addr_o       = AddrTx;
                    uart_wr_data_o       = {24'h0, req_data_i[{grant_q, 3'b000} +: 8]};
                    req_ready_o[grant_q] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign init_done_o = init_done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of expected UART writes plus table vectors and
// hand-written sequences for rotation, timeout, mid-byte reset and locking.
module tb_uart_tx_arbiter;

    localparam logic [31:0] Base  = 32'h3000_0000;
    localparam logic [31:0] ACtrl = Base + 32'h00;
    localparam logic [31:0] AStat = Base + 32'h04;
    localparam logic [31:0] ABaud = Base + 32'h08;
    localparam logic [31:0] ATx   = Base + 32'h0C;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  ready;
    } wr_t;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        int         busy;
        logic [1:0] exp_ready;
        logic [7:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_to_n;
    logic [1:0]  req_valid, req_lock, req_ready;
    logic [15:0] req_data;
    logic        wr_en, init_done, timeout;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [1:0]  to_valid, to_ready;
    logic        to_busy, to_wr_en, to_init_done, to_timeout;
    logic [31:0] to_wr_addr, to_wr_data, to_rd_addr, to_rd_data;

    int   cyc = 0, polls = 0, busy_until = 0;
    int   n_chk = 0, n_pass = 0;
    int   tx_count = 0, tx_cyc = 0, prev_tx_cyc = 0;
    int   n0, t0, i0, i1;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[6];
    logic [23:0] lock_b0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_lock_i     (req_lock),
        .req_ready_o    (req_ready),
        .uart_wr_en_o   (wr_en),
        .uart_wr_addr_o (wr_addr),
        .uart_wr_data_o (wr_data),
        .uart_rd_addr_o (rd_addr),
        .uart_rd_data_i (rd_data),
        .init_done_o    (init_done),
        .timeout_o      (timeout)
    );

    uart_tx_arbiter #(.POLL_TIMEOUT(8)) dut_to (
        .clk_i          (clk),
        .rst_n_i        (rst_to_n),
        .req_valid_i    (to_valid),
        .req_data_i     (req_data),
        .req_lock_i     (req_lock),
        .req_ready_o    (to_ready),
        .uart_wr_en_o   (to_wr_en),
        .uart_wr_addr_o (to_wr_addr),
        .uart_wr_data_o (to_wr_data),
        .uart_rd_addr_o (to_rd_addr),
        .uart_rd_data_i (to_rd_data),
        .init_done_o    (to_init_done),
        .timeout_o      (to_timeout)
    );

    // UART status model: busy until the DUT has polled busy_until times in total.
    assign rd_data    = {31'b0, polls < busy_until};
    assign to_rd_data = {31'b0, to_busy};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_addr == AStat) polls <= polls + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        wr_t w;
        w.addr  = a;
        w.data  = d;
        w.ready = r;
        exp_q.push_back(w);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int c = 0;
        while (tx_count < target && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("tx_wait", tx_count, target);
    endtask

    // Scoreboard: every bus write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_wr: got addr %0h data %0h, required no write",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bus_write", {wr_addr, wr_data, req_ready}, {mon_e.addr, mon_e.data, mon_e.ready});
                chk("ready_onehot", $onehot0(req_ready), 1'b1);
            end
            if (wr_addr == ATx) begin
                prev_tx_cyc = tx_cyc;
                tx_cyc      = cyc;
                tx_count++;
            end
        end else if (rst_n && req_ready != 2'b00) begin
            n_chk++;
            $display("FAIL ready_without_write: got ready %b, required 00", req_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 8'h41, 8'h99, 0, 2'b01, 8'h41};
        vecs[1] = '{2'b10, 8'h12, 8'h5A, 0, 2'b10, 8'h5A};
        vecs[2] = '{2'b01, 8'h7E, 8'h3C, 3, 2'b01, 8'h7E};
        vecs[3] = '{2'b10, 8'hAA, 8'h00, 10, 2'b10, 8'h00};
        vecs[4] = '{2'b10, 8'h55, 8'hFF, 0, 2'b10, 8'hFF};
        vecs[5] = '{2'b01, 8'h80, 8'h01, 1, 2'b01, 8'h80};
        lock_b0 = 24'h63_62_61;

        rst_n = 1'b0; rst_to_n = 1'b0; req_valid = '0; req_lock = '0; req_data = '0;
        to_valid = '0; to_busy = 1'b0; busy_until = 0;
        #3;
        chk("reset_outputs", {wr_en, wr_addr, wr_data, rd_addr, req_ready, init_done, timeout}, '0);

        // Init sequence
        exp_wr(ABaud, 32'd434, 2'b00);
        exp_wr(ACtrl, 32'h1, 2'b00);
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk); #1; chk("init_done_baud", init_done, 1'b0);
        @(negedge clk); #1; chk("init_done_ctrl", init_done, 1'b0);
        @(negedge clk); #1; chk("idle_after_init", {init_done, wr_en, rd_addr}, {1'b1, 1'b0, 32'h0});
        chk("init_writes", exp_q.size(), 0);

        // Table: single requests with varying STATUS busy time
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            busy_until = polls + vecs[i].busy;
            req_data   = {vecs[i].d1, vecs[i].d0};
            req_valid  = vecs[i].valid;
            exp_wr(ATx, {24'h0, vecs[i].exp_data}, vecs[i].exp_ready);
            t0 = cyc;
            n0 = tx_count;
            wait_tx(n0 + 1, 40);
            chk("latency", tx_cyc - t0, 2 + vecs[i].busy);
            req_valid = '0;
            repeat (2) @(negedge clk);
        end

        // Both requesters continuously valid: grants alternate every 4 cycles
        n0 = tx_count;
        for (int k = 0; k < 6; k++)
            exp_wr(ATx, (k % 2 == 0) ? 32'h31 : 32'h30, (k % 2 == 0) ? 2'b10 : 2'b01);
        @(negedge clk); #1;
        req_data  = {8'h31, 8'h30};
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_tx(n0 + k + 1, 20);
            if (k > 0) chk("rr_spacing", tx_cyc - prev_tx_cyc, 4);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Timeout on the POLL_TIMEOUT=8 instance with STATUS stuck busy
        @(posedge clk); #2; rst_to_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        req_data = {8'h00, 8'h5C};
        to_busy  = 1'b1;
        to_valid = 2'b01;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk); #1;
            chk("to_polling", {to_wr_en, to_ready, to_timeout, to_rd_addr}, {1'b0, 2'b00, 1'b0, AStat});
        end
        @(negedge clk); #1;
        chk("to_abort", {to_wr_en, to_ready, to_timeout, to_rd_addr}, {1'b0, 2'b00, 1'b1, 32'h0});
        to_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("to_retry", {to_wr_en, to_wr_addr, to_wr_data, to_ready, to_timeout},
            {1'b1, ATx, 32'h5C, 2'b01, 1'b1});
        to_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("to_sticky", to_timeout, 1'b1);

        // Asynchronous reset in the middle of POLL, then clean restart
        busy_until = polls + 5;
        req_data   = {8'h00, 8'h55};
        req_valid  = 2'b01;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_poll", {wr_en, wr_addr, wr_data, rd_addr, req_ready, init_done, timeout}, '0);
        @(posedge clk); #2;
        busy_until = polls;
        exp_wr(ABaud, 32'd434, 2'b00);
        exp_wr(ACtrl, 32'h1, 2'b00);
        exp_wr(ATx, 32'h55, 2'b01);
        n0 = tx_count;
        rst_n = 1'b1;
        wait_tx(n0 + 1, 20);
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("post_reset_drained", exp_q.size(), 0);

        // req0 sends 3 bytes with lock while req1 joins after the first
`ifdef UART_TX_ARB_LOCK_EN
        exp_wr(ATx, 32'h61, 2'b01);
        exp_wr(ATx, 32'h62, 2'b01);
        exp_wr(ATx, 32'h63, 2'b01);
        exp_wr(ATx, 32'h71, 2'b10);
`else
        exp_wr(ATx, 32'h61, 2'b01);
        exp_wr(ATx, 32'h71, 2'b10);
        exp_wr(ATx, 32'h62, 2'b01);
        exp_wr(ATx, 32'h63, 2'b01);
`endif
        i0 = 0;
        i1 = 0;
        @(negedge clk); #1;
        req_data  = {8'h71, 8'h61};
        req_valid = 2'b01;
        req_lock  = 2'b01;
        for (int c = 0; c < 80 && (i0 < 3 || i1 < 1); c++) begin
            @(negedge clk); #1;
            if (req_ready[0]) i0++;
            if (req_ready[1]) i1++;
            req_valid[0] = (i0 < 3);
            req_lock[0]  = (i0 < 3);
            req_valid[1] = (i0 >= 1) && (i1 < 1);
            if (i0 < 3) req_data[7:0] = lock_b0[8*i0 +: 8];
        end
        chk("lock_seq_done", {i0, i1}, {32'd3, 32'd1});
        req_valid = '0;
        req_lock  = '0;
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
